// File: rtl/bomb_fuse_matrix_pkg.sv
// Shared types and default sizing for the bomb fuse matrix display.
// Game states, colour selection and the default matrix geometry.
package bomb_pkg;

    localparam int DEF_ROWS      = 8;
    localparam int DEF_COLS      = 8;
    localparam int DEF_FUSE_ROWS = 4;
    localparam int DEF_TICK_DIV  = 2500;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BURN     = 2'd1,
        ST_DEFUSED  = 2'd2,
        ST_EXPLODED = 2'd3
    } game_state_e;

    typedef enum logic [1:0] {
        CLR_OFF    = 2'd0,
        CLR_RED    = 2'd1,
        CLR_GREEN  = 2'd2,
        CLR_YELLOW = 2'd3
    } colour_e;

endpackage

// File: rtl/bomb_fuse_matrix_if.sv
// Game-switch and matrix-driver signal bundle for the bomb fuse matrix.
interface bomb_fuse_matrix_if
    import bomb_pkg::*;
#(
    parameter int ROWS      = DEF_ROWS,
    parameter int COLS      = DEF_COLS,
    parameter int FUSE_ROWS = DEF_FUSE_ROWS
);
    localparam int FW = $clog2(FUSE_ROWS + 1);

    logic            en;
    logic            start;
    logic            defuse;
    logic [ROWS-1:0] hang;
    logic [COLS-1:0] red;
    logic [COLS-1:0] gre;
    logic            fail;
    logic            defused;
    logic [FW-1:0]   fuse_left;

    modport master (
        output en, start, defuse,
        input  hang, red, gre, fail, defused, fuse_left
    );

    modport slave (
        input  en, start, defuse,
        output hang, red, gre, fail, defused, fuse_left
    );

endinterface

// File: rtl/bomb_fuse_matrix_row_pattern.sv
// Combinational image generator: column drive for one matrix row given
// the game state, the remaining fuse length and the explosion blink phase.
module bomb_row_pattern
    import bomb_pkg::*;
#(
    parameter int ROWS      = DEF_ROWS,
    parameter int COLS      = DEF_COLS,
    parameter int FUSE_ROWS = DEF_FUSE_ROWS,
    parameter int RW        = $clog2(DEF_ROWS),
    parameter int FW        = $clog2(DEF_FUSE_ROWS + 1)
)(
    input  logic [RW-1:0]   row,
    input  logic [FW-1:0]   fuse_left,
    input  game_state_e     state,
    input  logic            blink,
    output logic [COLS-1:0] red,
    output logic [COLS-1:0] gre
);
    localparam int          C0       = COLS / 2 - 1;
    localparam int          C1       = COLS / 2;
    localparam logic [31:0] FUSE_U   = 32'(FUSE_ROWS);
    localparam logic [31:0] LAST_U   = 32'(ROWS - 1);

    logic [31:0]     row_ext_s;
    logic [31:0]     fuse_ext_s;
    logic            fuse_row_s;
    logic            fuse_lit_s;
    logic [COLS-1:0] mask_s;
    colour_e         colour_s;

    // Shape and colour selection for the addressed row.
    always_comb begin
        row_ext_s  = 32'(row);
        fuse_ext_s = 32'(fuse_left);
        fuse_row_s = (row_ext_s < FUSE_U);
        // r >= FUSE_ROWS - fuse_left, rearranged so nothing can underflow
        fuse_lit_s = ((row_ext_s + fuse_ext_s) >= FUSE_U);

        mask_s = '0;
        if (fuse_row_s || (row_ext_s == FUSE_U) || (row_ext_s == LAST_U)) begin
            mask_s[C0] = 1'b1;
            mask_s[C1] = 1'b1;
        end else begin
            mask_s[C0 - 1] = 1'b1;
            mask_s[C1 + 1] = 1'b1;
        end

        case (state)
            ST_IDLE, ST_BURN: begin
                if (fuse_row_s) begin
                    colour_s = fuse_lit_s ? CLR_YELLOW : CLR_OFF;
                end else begin
                    colour_s = CLR_RED;
                end
            end
            ST_DEFUSED: begin
                if (fuse_row_s) begin
                    colour_s = fuse_lit_s ? CLR_GREEN : CLR_OFF;
                end else begin
                    colour_s = CLR_GREEN;
                end
            end
            ST_EXPLODED: colour_s = blink ? CLR_RED : CLR_OFF;
            default:     colour_s = CLR_OFF;
        endcase

        red = ((colour_s == CLR_RED)   || (colour_s == CLR_YELLOW)) ? mask_s : '0;
        gre = ((colour_s == CLR_GREEN) || (colour_s == CLR_YELLOW)) ? mask_s : '0;
    end

endmodule

// File: rtl/bomb_fuse_matrix.sv
// Bomb fuse matrix top: game FSM, fuse tick, row scan and blink counters,
// with registered row-select and column drive outputs.
module bomb_fuse_matrix
    import bomb_pkg::*;
#(
    parameter int ROWS      = DEF_ROWS,
    parameter int COLS      = DEF_COLS,
    parameter int FUSE_ROWS = DEF_FUSE_ROWS,
    parameter int TICK_DIV  = DEF_TICK_DIV
)(
    input  logic              clk,
    input  logic              rst_n,
    bomb_fuse_matrix_if.slave bus
);
    localparam int RW = $clog2(ROWS);
    localparam int FW = $clog2(FUSE_ROWS + 1);
    localparam int TW = $clog2(TICK_DIV);

    game_state_e     state_r;
    game_state_e     state_nxt_s;
    logic [TW-1:0]   tick_r;
    logic [TW-1:0]   tick_nxt_s;
    logic [TW-1:0]   blink_cnt_r;
    logic [TW-1:0]   blink_cnt_nxt_s;
    logic            blink_r;
    logic            blink_nxt_s;
    logic [FW-1:0]   fuse_left_r;
    logic [FW-1:0]   fuse_nxt_s;
    logic            fail_r;
    logic            fail_nxt_s;
    logic            defused_r;
    logic            defused_nxt_s;
    logic [RW-1:0]   row_r;
    logic [RW-1:0]   row_nxt_s;
    logic [ROWS-1:0] hang_r;
    logic [ROWS-1:0] hang_nxt_s;
    logic [COLS-1:0] red_r;
    logic [COLS-1:0] gre_r;
    logic [COLS-1:0] pat_red_s;
    logic [COLS-1:0] pat_gre_s;
    logic            tick_wrap_s;
    logic            blink_wrap_s;

    bomb_row_pattern #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .FUSE_ROWS (FUSE_ROWS),
        .RW        (RW),
        .FW        (FW)
    ) u_pattern (
        .row       (row_r),
        .fuse_left (fuse_left_r),
        .state     (state_r),
        .blink     (blink_r),
        .red       (pat_red_s),
        .gre       (pat_gre_s)
    );

    assign tick_wrap_s  = bus.start && (tick_r == TW'(TICK_DIV - 1));
    assign blink_wrap_s = (blink_cnt_r == TW'(TICK_DIV - 1));

    // Game FSM next state, fuse/tick/blink bookkeeping and row scan.
    always_comb begin
        state_nxt_s     = state_r;
        tick_nxt_s      = tick_r;
        fuse_nxt_s      = fuse_left_r;
        fail_nxt_s      = fail_r;
        defused_nxt_s   = defused_r;
        blink_nxt_s     = 1'b0;
        blink_cnt_nxt_s = '0;

        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    // the launching cycle already counts as one burn cycle
                    state_nxt_s = ST_BURN;
                    tick_nxt_s  = TW'(1);
                end else begin
                    tick_nxt_s  = '0;
                end
            end
            ST_BURN: begin
                if (bus.defuse) begin
                    state_nxt_s   = ST_DEFUSED;
                    defused_nxt_s = 1'b1;
                end else if (tick_wrap_s) begin
                    tick_nxt_s  = '0;
                    fuse_nxt_s  = fuse_left_r - FW'(1);
                    fail_nxt_s  = (fuse_left_r == FW'(1));
                    state_nxt_s = (fuse_left_r == FW'(1)) ? ST_EXPLODED : ST_BURN;
                end else if (bus.start) begin
                    tick_nxt_s  = tick_r + TW'(1);
                end else begin
                    tick_nxt_s  = tick_r;
                end
            end
            ST_DEFUSED: begin
                state_nxt_s = ST_DEFUSED;
            end
            ST_EXPLODED: begin
                if (blink_wrap_s) begin
                    blink_cnt_nxt_s = '0;
                    blink_nxt_s     = ~blink_r;
                end else begin
                    blink_cnt_nxt_s = blink_cnt_r + TW'(1);
                    blink_nxt_s     = blink_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        row_nxt_s = (row_r == RW'(ROWS - 1)) ? '0 : row_r + RW'(1);
        for (int i = 0; i < ROWS; i++) begin
            hang_nxt_s[i] = (i != (ROWS - 1 - int'(row_r)));
        end
    end

    // State and output registers; reset and disable share the idle image.
    always_ff @(posedge clk) begin
        if (!rst_n || !bus.en) begin
            state_r     <= ST_IDLE;
            tick_r      <= '0;
            blink_cnt_r <= '0;
            blink_r     <= 1'b0;
            fuse_left_r <= FW'(FUSE_ROWS);
            fail_r      <= 1'b0;
            defused_r   <= 1'b0;
            row_r       <= '0;
            hang_r      <= '1;
            red_r       <= '0;
            gre_r       <= '0;
        end else begin
            state_r     <= state_nxt_s;
            tick_r      <= tick_nxt_s;
            blink_cnt_r <= blink_cnt_nxt_s;
            blink_r     <= blink_nxt_s;
            fuse_left_r <= fuse_nxt_s;
            fail_r      <= fail_nxt_s;
            defused_r   <= defused_nxt_s;
            row_r       <= row_nxt_s;
            hang_r      <= hang_nxt_s;
            red_r       <= pat_red_s;
            gre_r       <= pat_gre_s;
        end
    end

    assign bus.hang      = hang_r;
    assign bus.red       = red_r;
    assign bus.gre       = gre_r;
    assign bus.fail      = fail_r;
    assign bus.defused   = defused_r;
    assign bus.fuse_left = fuse_left_r;

endmodule

// File: tb/tb_bomb_fuse_matrix.sv
// Self-checking bench for bomb_fuse_matrix: a behavioural game model feeds a
// scoreboard queue each cycle, plus directed checks of the documented images.
module tb_bomb_fuse_matrix;
    import bomb_pkg::*;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int FUSE = 4;
    localparam int TD   = 4;

    localparam int M_IDLE = 0;
    localparam int M_BURN = 1;
    localparam int M_DEF  = 2;
    localparam int M_EXPL = 3;

    typedef struct packed {
        logic [7:0] hang;
        logic [7:0] red;
        logic [7:0] gre;
        logic       fail;
        logic       defused;
        logic [2:0] fuse;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    int   m_state, m_burned, m_fuse, m_row, m_bcnt, m_blink, m_fail, m_def;

    always #5 clk = ~clk;

    bomb_fuse_matrix_if #(.ROWS(ROWS), .COLS(COLS), .FUSE_ROWS(FUSE)) bif ();

    bomb_fuse_matrix #(
        .ROWS(ROWS), .COLS(COLS), .FUSE_ROWS(FUSE), .TICK_DIV(TD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void row_image(input int r, input int f, input int st, input int b,
                                      output logic [7:0] rd, output logic [7:0] gr);
        logic [7:0] shape;
        shape = (r <= FUSE || r == ROWS - 1) ? 8'b0001_1000 : 8'b0010_0100;
        rd = 8'h00;
        gr = 8'h00;
        if (st == M_EXPL) begin
            if (b != 0) rd = shape;
        end else if (r < FUSE) begin
            if (r >= FUSE - f) begin
                if (st == M_DEF) gr = shape;
                else begin rd = shape; gr = shape; end
            end
        end else begin
            if (st == M_DEF) gr = shape;
            else rd = shape;
        end
    endfunction

    task automatic model_step(input logic r, input logic e, input logic s, input logic d,
                              output exp_t x);
        logic [7:0] h, rd, gr;
        if (!r || !e) begin
            m_state = M_IDLE; m_burned = 0; m_fuse = FUSE; m_row = 0;
            m_bcnt = 0; m_blink = 0; m_fail = 0; m_def = 0;
            h = 8'hFF; rd = 8'h00; gr = 8'h00;
        end else begin
            h = 8'hFF;
            h[ROWS - 1 - m_row] = 1'b0;
            row_image(m_row, m_fuse, m_state, m_blink, rd, gr);
            m_row = (m_row + 1) % ROWS;
            case (m_state)
                M_IDLE: if (s) begin m_state = M_BURN; m_burned = 1; end
                M_BURN: begin
                    if (d) begin
                        m_state = M_DEF; m_def = 1;
                    end else if (s) begin
                        m_burned++;
                        if (m_burned % TD == 0) begin
                            m_fuse--;
                            if (m_fuse == 0) begin m_state = M_EXPL; m_fail = 1; end
                        end
                    end
                end
                M_EXPL: begin
                    m_bcnt++;
                    if (m_bcnt == TD) begin m_bcnt = 0; m_blink = 1 - m_blink; end
                end
                default: ;
            endcase
        end
        x.hang = h; x.red = rd; x.gre = gr;
        x.fail = 1'(m_fail); x.defused = 1'(m_def); x.fuse = 3'(m_fuse);
    endtask

    task automatic drive(input logic r, input logic e, input logic s, input logic d);
        exp_t x;
        @(negedge clk);
        rst_n = r; bif.en = e; bif.start = s; bif.defuse = d;
        model_step(r, e, s, d, x);
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_empty: got=0 expected=1 entries");
        end else begin
            x = sb_q.pop_front();
            check_val("sb_hang",    32'(bif.hang),      32'(x.hang));
            check_val("sb_red",     32'(bif.red),       32'(x.red));
            check_val("sb_gre",     32'(bif.gre),       32'(x.gre));
            check_val("sb_fail",    32'(bif.fail),      32'(x.fail));
            check_val("sb_defused", 32'(bif.defused),   32'(x.defused));
            check_val("sb_fuse",    32'(bif.fuse_left), 32'(x.fuse));
        end
    endtask

    task automatic run(input int n, input logic r, input logic e, input logic s, input logic d);
        for (int i = 0; i < n; i++) drive(r, e, s, d);
    endtask

    initial begin
        bif.en = 1'b0; bif.start = 1'b0; bif.defuse = 1'b0;
        run(2, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("rst_hang", 32'(bif.hang), 32'h0000_00FF);
        check_val("rst_fuse", 32'(bif.fuse_left), 32'd4);

        // idle scan: yellow fuse on row 0, wide red body on row 5
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check_val("row0_hang", 32'(bif.hang), 32'h0000_007F);
        check_val("row0_red",  32'(bif.red),  32'h0000_0018);
        check_val("row0_gre",  32'(bif.gre),  32'h0000_0018);
        run(4, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check_val("row5_hang", 32'(bif.hang), 32'h0000_00FB);
        check_val("row5_red",  32'(bif.red),  32'h0000_0024);
        check_val("row5_gre",  32'(bif.gre),  32'h0000_0000);
        run(10, 1'b1, 1'b1, 1'b0, 1'b1);
        check_val("idle_defuse_ignored", 32'(bif.defused), 32'd0);

        // continuous burn to explosion, then blinking
        run(4, 1'b1, 1'b1, 1'b1, 1'b0);
        check_val("burn_step1", 32'(bif.fuse_left), 32'd3);
        run(12, 1'b1, 1'b1, 1'b1, 1'b0);
        check_val("explode_fail", 32'(bif.fail), 32'd1);
        check_val("explode_fuse", 32'(bif.fuse_left), 32'd0);
        run(14, 1'b1, 1'b1, 1'b1, 1'b1);
        check_val("expl_defuse_ignored", 32'(bif.defused), 32'd0);

        // pause/resume then defuse at fuse_left=2
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        run(6, 1'b1, 1'b1, 1'b1, 1'b0);
        run(10, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("pause_hold", 32'(bif.fuse_left), 32'd3);
        run(2, 1'b1, 1'b1, 1'b1, 1'b0);
        check_val("resume_step", 32'(bif.fuse_left), 32'd2);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        check_val("defuse_flag", 32'(bif.defused), 32'd1);
        run(20, 1'b1, 1'b1, 1'b1, 1'b0);
        run(5, 1'b1, 1'b1, 1'b0, 1'b1);
        check_val("defused_fuse_frozen", 32'(bif.fuse_left), 32'd2);
        check_val("defused_no_fail", 32'(bif.fail), 32'd0);

        // defuse on the same cycle as the final wrap
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        run(15, 1'b1, 1'b1, 1'b1, 1'b0);
        check_val("pre_final_fuse", 32'(bif.fuse_left), 32'd1);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        check_val("race_defused", 32'(bif.defused), 32'd1);
        check_val("race_fail", 32'(bif.fail), 32'd0);
        check_val("race_fuse", 32'(bif.fuse_left), 32'd1);
        run(8, 1'b1, 1'b1, 1'b1, 1'b0);

        // en=0 mid-burn blanks and returns to idle
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        run(6, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        check_val("dis_hang", 32'(bif.hang), 32'h0000_00FF);
        check_val("dis_red",  32'(bif.red),  32'h0000_0000);
        check_val("dis_gre",  32'(bif.gre),  32'h0000_0000);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check_val("reen_fuse", 32'(bif.fuse_left), 32'd4);
        check_val("reen_hang", 32'(bif.hang), 32'h0000_007F);

        // reset while exploded
        run(20, 1'b1, 1'b1, 1'b1, 1'b0);
        check_val("pre_rst_fail", 32'(bif.fail), 32'd1);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        check_val("rst_expl_hang", 32'(bif.hang), 32'h0000_00FF);
        check_val("rst_expl_fail", 32'(bif.fail), 32'd0);
        check_val("rst_expl_fuse", 32'(bif.fuse_left), 32'd4);
        run(3, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bomb_fuse_matrix.md
# bomb_fuse_matrix

Parametrised successor of the single-image bomb display: drives a ROWS×COLS dual-colour (red/green) LED matrix showing a bomb whose fuse burns down one row per tick. It adds a defuse input, a pause/resume on `start`, an explicit game FSM, and a blinking explosion image. It sits between the game's input switches and the matrix row/column drivers, and reports `fail`/`defused` to the scoring logic.

## Interface
- `ROWS`, 8, matrix rows (≥ FUSE_ROWS+2)
- `COLS`, 8, matrix columns (even, ≥4)
- `FUSE_ROWS`, 4, top rows used for the fuse
- `TICK_DIV`, 2500, clk cycles per fuse step and per explosion blink toggle
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `en`  in  1  display/game enable (master switch); 0 blanks the matrix and returns the game to IDLE
- `start`  in  1  level; 1 = fuse burning, 0 = paused
- `defuse`  in  1  single-cycle pulse; defuses the bomb while burning
- `hang`  out  ROWS  row select, active-low one-hot; bit ROWS-1 = top row
- `red`  out  COLS  red column drive, active-high
- `gre`  out  COLS  green column drive, active-high
- `fail`  out  1  bomb exploded (sticky until IDLE)
- `defused`  out  1  bomb defused (sticky until IDLE)
- `fuse_left`  out  $clog2(FUSE_ROWS+1)  fuse rows still lit

## Operation
- Reset (rst_n=0 at edge): hang all 1, red=gre=0, fail=0, defused=0, fuse_left=FUSE_ROWS, state IDLE, row counter 0, tick counter 0, blink phase 0.
- en=0: same values as reset except nothing else is required to hold; on re-enable the game restarts from IDLE.
- FSM states: IDLE, BURN, DEFUSED, EXPLODED.
  - IDLE → BURN when start=1; tick counter cleared.
  - BURN: tick counter increments only while start=1 (holds when 0); wraps at TICK_DIV-1, each wrap decrements fuse_left. Wrap that takes fuse_left 1→0 → EXPLODED, fail=1.
  - BURN, defuse=1 → DEFUSED, defused=1, fuse_left frozen. defuse and final wrap in the same cycle: DEFUSED wins, fail stays 0.
  - DEFUSED, EXPLODED: terminal until en=0 or reset; start/defuse ignored.
  - defuse outside BURN ignored.
- Scan: row counter r cycles 0..ROWS-1, one row per clk while en=1; hang bit ROWS-1-r is 0.
- Image for row r (c0=COLS/2-1, c1=COLS/2):
  - Fuse row r<FUSE_ROWS: cols c0,c1 lit if r ≥ FUSE_ROWS-fuse_left (top row extinguishes first).
  - Body first/last row (r=FUSE_ROWS, r=ROWS-1): cols c0,c1; other body rows: cols c0-1, c1+1.
- Colours: IDLE/BURN fuse yellow (red+gre), body red. DEFUSED: fuse and body green only. EXPLODED: fuse-shape (all FUSE_ROWS) and body red when blink phase=1, all off when 0; blink phase toggles every TICK_DIV cycles.

## Timing
- hang/red/gre registered: pattern for row r appears the edge after the row counter holds r; first lit row one cycle after en=1 / rst_n release.
- fuse_left, fail, defused update on the edge the tick wrap / defuse is sampled; image reflects the new value from the next row output.
- fuse step period exactly TICK_DIV cycles of start=1; full burn = FUSE_ROWS·TICK_DIV start-high cycles.
- Reset and en=0 take priority over every FSM transition in the same cycle.

## Structure
- Package `bomb_pkg`: FSM state enum, colour-select enum (OFF/RED/GREEN/YELLOW), default parameter constants.
- Sub-module `bomb_row_pattern`: combinational; inputs row index, fuse_left, state, blink phase; outputs red/gre column vectors. Top holds FSM, tick, row and blink counters, output registers.

## Test plan
- TICK_DIV=4, defaults, en=1, start=0: hang sequence 01111111,10111111,…,11111110; row0 red=gre=00011000; row5 red=00100100 gre=0; fuse_left=4, fail=0.
- start=1 held: fuse_left 4→3 after 4 cycles, row0 then red=gre=0; after 16 cycles fail=1, EXPLODED, rows blink red/off every 4 cycles.
- start=1 6 cycles, 0 for 10, then 1: fuse_left holds 3 during pause, reaches 2 after 2 more start-high cycles.
- defuse at fuse_left=2: defused=1, rows 2,3 gre=00011000 red=0, body gre only; further start/defuse no change, fail stays 0.
- defuse coincident with final wrap: defused=1, fail=0, fuse_left=1.
- en=0 mid-BURN → next edge hang=11111111, red=gre=0; en=1 → IDLE, fuse_left=4. rst_n=0 in EXPLODED → all reset values next edge.
